// File: rtl/enoc_switch_allocator.sv
// ENoC switch allocator: one round-robin, wormhole-locking arbiter per output port.
// Grants are combinational from the current requests; arbiter state advances on clk.

module enoc_sa_out_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       en,
   input  logic [0:4] req,
   input  logic [0:4] tail,
   output logic [0:4] grant
);

   logic       lock, lock_nxt;
   logic [2:0] owner, owner_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic       gnt_any;
   logic [2:0] gnt_idx;
   logic [2:0] idx;

   function automatic logic [2:0] inc5(input logic [2:0] v);
      return (v == 3'd4) ? 3'd0 : v + 3'd1;
   endfunction

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = ptr;
      grant   = '0;
      if (!reset && ce && en) begin
         if (lock) begin
            // Locked output only serves its owner; a dropped request is a bubble.
            if (req[owner]) begin
               gnt_any = 1'b1;
               gnt_idx = owner;
            end
         end else begin
            for (int k = 0; k < 5; k++) begin
               if (!gnt_any && req[idx]) begin
                  gnt_any = 1'b1;
                  gnt_idx = idx;
               end
               idx = inc5(idx);
            end
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   always_comb begin
      lock_nxt  = lock;
      owner_nxt = owner;
      ptr_nxt   = ptr;
      if (gnt_any) begin
         if (lock) begin
            if (tail[owner]) begin
               lock_nxt = 1'b0;
               ptr_nxt  = inc5(owner);
            end
         end else if (tail[gnt_idx]) begin
            ptr_nxt = inc5(gnt_idx);
         end else begin
            lock_nxt  = 1'b1;
            owner_nxt = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock  <= 1'b0;
         owner <= '0;
         ptr   <= '0;
      end else begin
         lock  <= lock_nxt;
         owner <= owner_nxt;
         ptr   <= ptr_nxt;
      end
   end

endmodule

module enoc_switch_allocator (
   input  logic            clk,
   input  logic            reset,
   input  logic            ce,
   input  logic [0:4][0:4] i_output_req,
   input  logic [0:4]      i_tail,
   input  logic [0:4]      i_en,
   output logic [0:4][0:4] o_output_grant,
   output logic [0:4]      o_input_grant
);

   localparam int PORTS = 5;

   logic [0:PORTS-1][0:PORTS-1] req_vld;
   logic [0:PORTS-1][0:PORTS-1] req_col;

   // Malformed (non one-hot) request rows are dropped, then transposed to [out][in].
   always_comb begin
      for (int i = 0; i < PORTS; i++)
         req_vld[i] = $onehot(i_output_req[i]) ? i_output_req[i] : '0;
   end

   always_comb begin
      for (int o = 0; o < PORTS; o++)
         for (int i = 0; i < PORTS; i++)
            req_col[o][i] = req_vld[i][o];
   end

   for (genvar o = 0; o < PORTS; o++) begin : g_out
      enoc_sa_out_arb u_arb (
         .clk   (clk),
         .reset (reset),
         .ce    (ce),
         .en    (i_en[o]),
         .req   (req_col[o]),
         .tail  (i_tail),
         .grant (o_output_grant[o])
      );
   end

   always_comb begin
      o_input_grant = '0;
      for (int i = 0; i < PORTS; i++)
         for (int o = 0; o < PORTS; o++)
            o_input_grant[i] = o_input_grant[i] | o_output_grant[o][i];
   end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: hand-built vector table for the directed scenarios,
// then random traffic checked against a behavioural per-output arbitration model.

module tb_enoc_switch_allocator;

   localparam logic [0:4] C = 5'b10000, N = 5'b01000, E = 5'b00100, S = 5'b00010, W = 5'b00001;
   localparam logic [0:4] Z = 5'b00000, ALL = 5'b11111, EOFF = 5'b11011, INV = 5'b00110;

   logic            clk = 1'b0;
   logic            reset, ce;
   logic [0:4][0:4] i_output_req, o_output_grant;
   logic [0:4]      i_tail, i_en, o_input_grant;

   int checks = 0;
   int errors = 0;

   int m_lock[5], m_owner[5], m_ptr[5];

   typedef struct {
      logic            rst;
      logic [0:4][0:4] req;
      logic [0:4]      tail;
      logic [0:4]      en;
      logic            ce;
      logic [0:4][0:4] og;
      logic [0:4]      ig;
   } vec_t;

   vec_t tbl[$];

   enoc_switch_allocator dut (
      .clk            (clk),
      .reset          (reset),
      .ce             (ce),
      .i_output_req   (i_output_req),
      .i_tail         (i_tail),
      .i_en           (i_en),
      .o_output_grant (o_output_grant),
      .o_input_grant  (o_input_grant)
   );

   always #5 clk = ~clk;

   // Reference: each input's target output (or -1), then per output pick by lock/owner or
   // by modulo-5 scan from the pointer.
   function automatic void model_grant(output logic [0:4][0:4] og, output logic [0:4] ig);
      int tgt[5];
      bit found;
      int i;
      for (int a = 0; a < 5; a++) begin
         tgt[a] = -1;
         if ($countones(i_output_req[a]) == 1)
            for (int o = 0; o < 5; o++)
               if (i_output_req[a][o]) tgt[a] = o;
      end
      og = '0;
      for (int o = 0; o < 5; o++) begin
         if (!reset && ce && i_en[o]) begin
            if (m_lock[o] != 0) begin
               if (tgt[m_owner[o]] == o) og[o][m_owner[o]] = 1'b1;
            end else begin
               found = 0;
               for (int k = 0; k < 5; k++) begin
                  i = (m_ptr[o] + k) % 5;
                  if (!found && tgt[i] == o) begin
                     og[o][i] = 1'b1;
                     found = 1;
                  end
               end
            end
         end
      end
      ig = '0;
      for (int a = 0; a < 5; a++)
         for (int o = 0; o < 5; o++)
            ig[a] = ig[a] | og[o][a];
   endfunction

   function automatic void model_update();
      logic [0:4][0:4] og;
      logic [0:4]      ig;
      model_grant(og, ig);
      for (int o = 0; o < 5; o++) begin
         if (reset) begin
            m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
         end else begin
            for (int i = 0; i < 5; i++) begin
               if (og[o][i]) begin
                  if (m_lock[o] != 0) begin
                     if (i_tail[i]) begin
                        m_lock[o] = 0;
                        m_ptr[o]  = (i + 1) % 5;
                     end
                  end else if (i_tail[i]) begin
                     m_ptr[o] = (i + 1) % 5;
                  end else begin
                     m_lock[o]  = 1;
                     m_owner[o] = i;
                  end
               end
            end
         end
      end
   endfunction

   task automatic add(input logic r, input logic [0:4][0:4] req, input logic [0:4] tail,
                      input logic [0:4] en, input logic c, input logic [0:4][0:4] og,
                      input logic [0:4] ig);
      vec_t v;
      v.rst = r; v.req = req; v.tail = tail; v.en = en; v.ce = c; v.og = og; v.ig = ig;
      tbl.push_back(v);
   endtask

   // Drive at negedge, compare 1 time unit later, advance the model at the posedge.
   task automatic do_cycle(input logic r, input logic [0:4][0:4] req, input logic [0:4] tail,
                           input logic [0:4] en, input logic c, input bit use_exp,
                           input logic [0:4][0:4] og_e, input logic [0:4] ig_e,
                           input string name);
      logic [0:4][0:4] mog;
      logic [0:4]      mig;
      reset = r; i_output_req = req; i_tail = tail; i_en = en; ce = c;
      #1;
      model_grant(mog, mig);
      if (!use_exp) begin
         og_e = mog;
         ig_e = mig;
      end
      checks++;
      if (o_output_grant !== og_e) begin
         errors++;
         $display("FAIL %s output_grant got %b exp %b", name, o_output_grant, og_e);
      end
      checks++;
      if (o_input_grant !== ig_e) begin
         errors++;
         $display("FAIL %s input_grant got %b exp %b", name, o_input_grant, ig_e);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [0:4][0:4] rq;
      logic [0:4]      tl, en;
      logic            rr, cc;
      int              sel;

      reset = 1'b1; ce = 1'b1; i_output_req = '0; i_tail = '0; i_en = '0;
      for (int o = 0; o < 5; o++) begin
         m_lock[o] = 0; m_owner[o] = 0; m_ptr[o] = 0;
      end

      // reset with everyone requesting, then n/e contend for s (round robin)
      add(1, {N,S,S,W,C}, ALL, ALL, 1, '0, Z);
      add(1, {N,S,S,W,C}, ALL, ALL, 1, '0, Z);
      add(0, {Z,S,S,Z,Z}, ALL, ALL, 1, {Z,Z,Z,N,Z}, N);
      add(0, {Z,S,S,Z,Z}, ALL, ALL, 1, {Z,Z,Z,E,Z}, E);
      add(0, {Z,S,S,Z,Z}, ALL, ALL, 1, {Z,Z,Z,N,Z}, N);
      add(0, {Z,S,S,Z,Z}, ALL, ALL, 1, {Z,Z,Z,E,Z}, E);
      // wormhole: w -> e, 3 flits, c waiting; afterwards ptr(e)=0 so c beats n
      add(0, {Z,Z,Z,Z,E}, Z,   ALL, 1, {Z,Z,W,Z,Z}, W);
      add(0, {E,Z,Z,Z,E}, Z,   ALL, 1, {Z,Z,W,Z,Z}, W);
      add(0, {E,Z,Z,Z,E}, W,   ALL, 1, {Z,Z,W,Z,Z}, W);
      add(0, {E,E,Z,Z,Z}, C|N, ALL, 1, {Z,Z,C,Z,Z}, C);
      add(0, {Z,E,Z,Z,Z}, N,   ALL, 1, {Z,Z,N,Z,Z}, N);
      // backpressure on e during a locked w packet
      add(0, {Z,Z,Z,Z,E}, Z, ALL,  1, {Z,Z,W,Z,Z}, W);
      add(0, {E,Z,Z,Z,E}, Z, EOFF, 1, '0, Z);
      add(0, {E,Z,Z,Z,E}, Z, EOFF, 1, '0, Z);
      add(0, {E,Z,Z,Z,E}, Z, ALL,  1, {Z,Z,W,Z,Z}, W);
      add(0, {E,Z,Z,Z,E}, W, ALL,  1, {Z,Z,W,Z,Z}, W);
      add(0, {E,Z,Z,Z,Z}, C, ALL,  1, {Z,Z,C,Z,Z}, C);
      // clock enable low mid-packet (s -> n locked)
      add(0, {Z,Z,Z,N,Z}, Z,   ALL, 1, {Z,S,Z,Z,Z}, S);
      add(0, {N,Z,W,N,Z}, C|E, ALL, 0, '0, Z);
      add(0, {N,Z,W,N,Z}, C|E, ALL, 0, '0, Z);
      add(0, {N,Z,W,N,Z}, C|E, ALL, 0, '0, Z);
      add(0, {N,Z,Z,N,Z}, C,   ALL, 1, {Z,S,Z,Z,Z}, S);
      add(0, {N,Z,Z,N,Z}, C|S, ALL, 1, {Z,S,Z,Z,Z}, S);
      add(0, {N,Z,Z,Z,Z}, C,   ALL, 1, {Z,C,Z,Z,Z}, C);
      // invalid request row never granted
      add(0, {Z,Z,Z,INV,Z}, ALL, ALL, 1, '0, Z);
      add(0, {E,Z,Z,INV,Z}, ALL, ALL, 1, {Z,Z,C,Z,Z}, C);
      // reset while e is locked to n: lock gone, ptr(e)=0
      add(0, {Z,E,Z,Z,Z}, Z, ALL, 1, {Z,Z,N,Z,Z}, N);
      add(1, {Z,E,Z,Z,Z}, Z, ALL, 1, '0, Z);
      add(0, {E,E,Z,Z,Z}, C, ALL, 1, {Z,Z,C,Z,Z}, C);
      add(0, {Z,E,Z,Z,Z}, N, ALL, 1, {Z,Z,N,Z,Z}, N);

      @(negedge clk);
      foreach (tbl[k])
         do_cycle(tbl[k].rst, tbl[k].req, tbl[k].tail, tbl[k].en, tbl[k].ce, 1'b1,
                  tbl[k].og, tbl[k].ig, $sformatf("vec%0d", k));

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 5; i++) begin
            rq[i] = '0;
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 8) rq[i][$urandom_range(0, 4)] = 1'b1;
            else if (sel == 9) rq[i] = 5'($urandom);
            tl[i] = 1'($urandom);
            en[i] = ($urandom_range(0, 4) != 0);
         end
         rr = ($urandom_range(0, 59) == 0);
         cc = ($urandom_range(0, 7) != 0);
         do_cycle(rr, rq, tl, en, cc, 1'b0, '0, '0, $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/enoc_switch_allocator.md
# enoc_switch_allocator

Per-router switch allocator for the ENoC mesh/torus router. Consumes the one-hot `[c,n,e,s,w]` output requests produced by each input port's route calculator and answers them with crossbar grants. Each output port has a round-robin arbiter with wormhole locking, so a multi-flit packet holds the output from head to tail. Sits between the five route calculators/input buffers and the 5x5 crossbar.

## Interface
- `PORTS`, 5, number of router ports; fixed at 5 with index order c=0, n=1, e=2, s=3, w=4.
- `clk`  in  1  router clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; low freezes all state and forces grants to 0.
- `i_output_req`  in  [0:4][0:4]  `[in][out]`; one-hot output request per input, all-zero = no request.
- `i_tail`  in  [0:4]  `[in]`; the flit currently presented by input `in` is the last flit of its packet. Single-flit packet = head with tail set.
- `i_en`  in  [0:4]  `[out]`; output port can accept a flit this cycle (downstream credit/ready).
- `o_output_grant`  out  [0:4][0:4]  `[out][in]`; one-hot crossbar select. A set bit means the flit from `in` is transferred to `out` this cycle.
- `o_input_grant`  out  [0:4]  `[in]`; pop strobe to input buffer, OR of `o_output_grant[*][in]`.

## Operation
**Request validity**
- A request row that is not one-hot (e.g. 5'b00110) is treated as all-zero for the whole cycle.

**Per-output state (independent for each output `o`)**
- `lock` (1 bit).
- `owner` (3 bits, 0..4).
- `ptr` (3 bits, 0..4): round-robin priority pointer.

**Arbitration when `lock=0`**
- Candidates are inputs `i` with a valid request for `o`.
- If any candidate exists, `i_en[o]=1` and `ce=1`, grant the first candidate found scanning `ptr, ptr+1, …` with modulo-5 wrap (4 → 0).
- If the granted flit has `i_tail=0`: next `lock=1`, `owner=i`.
- If the granted flit has `i_tail=1` (single flit): stay unlocked, next `ptr=(i+1) mod 5`.

**Arbitration when `lock=1`**
- Only `owner` can be granted, and only when it requests `o`, `i_en[o]=1` and `ce=1`.
- All other inputs are blocked.
- When the owner's tail flit is granted: next `lock=0`, `ptr=(owner+1) mod 5`.
- A locked owner whose request drops (bubble) keeps the lock; the grant is 0 that cycle.

**General rules**
- With no grant, `lock`, `owner` and `ptr` hold.
- The `i_en[o]=0` backpressure rule is identical: no grant, state holds, lock is retained.
- Each input presents at most one valid request, so it receives at most one grant per cycle and `o_input_grant` is one-bit-per-input exact.
- `ce=0`: all grants are 0 and no state changes.
- Reset (any time, including mid-packet): `lock=0`, `owner=0`, `ptr=0` on every output. Upstream is responsible for discarding partial packets.

## Timing
- Request → grant is combinational, zero-cycle latency. Grant is valid in the same cycle as `i_output_req`, `i_tail` and `i_en`.
- State updates at posedge `clk` from the current cycle's grants.
- Reset values: while `reset=1`, `o_output_grant=0` and `o_input_grant=0` (forced), and all state is cleared asynchronously.
- The first arbitration after reset deassertion favours input c (ptr=0).
- On a tail-grant cycle only the owner is granted. A waiting input is first eligible the next cycle, so one packet's tail and the next packet's head are never granted to the same output in one cycle.
- Throughput: one flit per output per cycle when `i_en` is high. There is no dead cycle between back-to-back packets from different inputs.
- Outputs of different ports are fully independent; up to 5 grants per cycle.

## Test plan
- **Reset:** assert `reset` asynchronously with all inputs requesting; deassert, then have n and e request s -> `o_output_grant[s]` is 0 while `reset=1`; first grant after deassert = n (5'b01000), ptr(s) becomes 2.
- **Round robin, single-flit:** n and e continuously request s with tail=1, `i_en[s]=1` -> grants to s alternate n, e, n, e on consecutive cycles; `o_input_grant` matches.
- **Wormhole lock:** w sends 3 flits to e (tail on flit 3); c requests e from cycle 2 -> e granted to w for cycles 1-3, c blocked; c granted cycle 4; ptr(e) = 0 after w's tail.
- **Backpressure:** during w's locked packet, `i_en[e]=0` for 2 cycles -> `o_output_grant[e]=0`, lock/owner held, c not granted; remaining w flits are granted when `i_en[e]` returns to 1.
- **Clock enable:** `ce=0` for 3 cycles mid-packet -> all grants 0, state frozen; after `ce=1`, the packet resumes at the next flit.
- **Invalid request and reset mid-packet:** input s requests 5'b00110 -> never granted. Assert reset while e is locked to n -> after reset, n's non-head flit competes as a new request; ptr(e) = 0.
